dmem_responder: RTL and testbench

//  Responder end of the core's data-port protocol (d_addr/d_data_w/d_data_we
//  in, d_data_r out). Implements word-addressed synchronous data RAM plus a

---
 rtl/dmem_if.sv | 14 +
 rtl/dmem_responder.sv | 68 ++++++
 tb/tb_dmem_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: data-port bus plus console drain handshake between core side and responder
interface dmem_if;
  logic [31:0] d_addr;
  logic [31:0] d_data_w;
  logic        d_data_we;
  logic [31:0] d_data_r;
  logic [7:0]  cons_data;
  logic        cons_valid;
  logic        cons_ready;
  modport master (output d_addr, d_data_w, d_data_we, cons_ready,
                  input  d_data_r, cons_data, cons_valid);
  modport slave  (input  d_addr, d_data_w, d_data_we, cons_ready,
                  output d_data_r, cons_data, cons_valid);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM plus MMIO console FIFO, FIFO status and cycle counter
module dmem_responder #(
  parameter int RAM_AW  = 12,
  parameter int FIFO_AW = 4
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);
  localparam int DEPTH = 2 ** FIFO_AW;
  logic [31:0]        r_ram  [2**RAM_AW];
  logic [7:0]         r_fifo [DEPTH];
  logic [FIFO_AW-1:0] r_head, r_tail;
  logic [FIFO_AW:0]   r_cnt;
  logic               r_ovf;
  logic [31:0]        r_cyc, r_rd;
  logic               w_mmio, w_full, w_empty, w_pop, w_push, w_acc, w_ovf_set, w_ovf_clr, w_cyc_wr;
  logic [1:0]         w_reg;
  logic [RAM_AW-1:0]  w_idx;
  logic [7:0]         w_cnt8;
  logic [31:0]        w_stat;
  logic               w_unused;
  assign w_mmio    = bus.d_addr[31];
  assign w_reg     = bus.d_addr[3:2];
  assign w_idx     = bus.d_addr[RAM_AW+1:2];
  assign w_full    = r_cnt == (FIFO_AW+1)'(DEPTH);
  assign w_empty   = r_cnt == '0;
  assign w_pop     = !w_empty && bus.cons_ready;
  assign w_push    = bus.d_data_we && w_mmio && w_reg == 2'd0;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign w_acc     = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;
  assign w_ovf_clr = bus.d_data_we && w_mmio && w_reg == 2'd1 && bus.d_data_w[2];
  assign w_cyc_wr  = bus.d_data_we && w_mmio && w_reg == 2'd2;
  assign w_cnt8    = 8'(r_cnt);
  assign w_stat    = {16'h0, w_cnt8, 5'h0, r_ovf, w_empty, w_full};
  assign w_unused  = ^{bus.d_addr, bus.d_data_w};
  assign bus.d_data_r   = r_rd;
  assign bus.cons_valid = !w_empty;
  assign bus.cons_data  = w_empty ? 8'h0 : r_fifo[r_head];
  // RAM word write; contents survive reset, writes during reset are dropped
  always_ff @(posedge clk)
    if (!reset && bus.d_data_we && !w_mmio) r_ram[w_idx] <= bus.d_data_w;
  // FIFO storage write at the tail for accepted pushes
  always_ff @(posedge clk)
    if (!reset && w_acc) r_fifo[r_tail] <= bus.d_data_w[7:0];
  // one-cycle read path; write cycles return zero
  always_ff @(posedge clk)
    if (reset) r_rd <= '0;
    else if (bus.d_data_we) r_rd <= '0;
    else if (!w_mmio) r_rd <= r_ram[w_idx];
    else r_rd <= w_reg == 2'd1 ? w_stat : w_reg == 2'd2 ? r_cyc : 32'h0;
  // FIFO pointers, sticky overflow (set beats clear) and cycle counter
  always_ff @(posedge clk)
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_cyc  <= '0;
    end else begin
      if (w_acc) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      r_cnt <= r_cnt + (FIFO_AW+1)'(w_acc) - (FIFO_AW+1)'(w_pop);
      r_ovf <= w_ovf_set || (r_ovf && !w_ovf_clr);
      r_cyc <= w_cyc_wr ? bus.d_data_w : r_cyc + 32'd1;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks against a queue/array reference model
module tb_dmem_responder;
  localparam logic [31:0] A_DATA = 32'h8000_0000;
  localparam logic [31:0] A_STAT = 32'h8000_0004;
  localparam logic [31:0] A_CYC  = 32'h8000_0008;
  localparam logic [31:0] A_RSV  = 32'h8000_000C;
  logic clk = 0, reset = 1;
  dmem_if bus();
  dmem_responder dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic [31:0] m_ram [int];
  logic [7:0]  m_q [$];
  logic        m_ovf = 0;
  logic [31:0] m_cyc = 0, exp_r = 0;
  bit          exp_known = 1;

  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic rdy, input logic rs);
    int idx, pre;
    bit pop, push, set;
    bus.d_addr = a; bus.d_data_w = wd; bus.d_data_we = we; bus.cons_ready = rdy; reset = rs;
    idx = int'(a[13:2]);
    if (rs) begin
      exp_r = 0; exp_known = 1; m_cyc = 0; m_q.delete(); m_ovf = 0;
    end else begin
      pre = m_q.size();
      pop = pre > 0 && rdy;
      exp_known = 1;
      if (we) exp_r = 0;
      else if (!a[31]) begin
        exp_known = m_ram.exists(idx);
        exp_r = exp_known ? m_ram[idx] : 32'h0;
      end else case (a[3:2])
        2'd1: exp_r = {16'h0, 8'(pre), 5'h0, m_ovf, pre == 0, pre == 16};
        2'd2: exp_r = m_cyc;
        default: exp_r = 0;
      endcase
      push = we && a[31] && a[3:2] == 2'd0;
      set = push && pre == 16 && !pop;
      if (pop) void'(m_q.pop_front());
      if (push && !set) m_q.push_back(wd[7:0]);
      if (we && a[31] && a[3:2] == 2'd1 && wd[2]) m_ovf = 0;
      if (set) m_ovf = 1;
      m_cyc = (we && a[31] && a[3:2] == 2'd2) ? wd : m_cyc + 1;
      if (we && !a[31]) m_ram[idx] = wd;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    total++; if (bus.d_data_r !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0", bus.d_data_r); end
    total++; if (bus.cons_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.cons_valid); end
    total++; if (bus.cons_data !== 8'h0) begin bad++; $display("FAIL reset_cdata got=%h exp=0", bus.cons_data); end
    cyc(A_STAT, 0, 0, 0, 0);
    total++; if (bus.d_data_r !== 32'h2) begin bad++; $display("FAIL reset_stat got=%h exp=2", bus.d_data_r); end
    cyc(A_CYC, 0, 0, 0, 0);
    total++; if (bus.d_data_r !== 32'h1) begin bad++; $display("FAIL reset_cyc got=%h exp=1", bus.d_data_r); end
  endtask

  task automatic test_ram;
    cyc(32'h10, 32'hDEADBEEF, 1, 0, 0);
    total++; if (bus.d_data_r !== 32'h0) begin bad++; $display("FAIL ram_wr_rd got=%h exp=0", bus.d_data_r); end
    cyc(32'h10, 0, 0, 0, 0);
    total++; if (bus.d_data_r !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_rd got=%h exp=deadbeef", bus.d_data_r); end
    cyc(32'h4010, 0, 0, 0, 0);
    total++; if (bus.d_data_r !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_alias got=%h exp=deadbeef", bus.d_data_r); end
  endtask

  task automatic test_latency;
    for (int i = 0; i < 3; i++) cyc(32'(i * 4), 32'(i + 1), 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(32'(i * 4), 0, 0, 0, 0);
      total++; if (bus.d_data_r !== 32'(i + 1)) begin bad++; $display("FAIL latency_%0d got=%h exp=%h", i, bus.d_data_r, i + 1); end
    end
  endtask

  task automatic test_fifo_ovf;
    for (int i = 0; i < 17; i++) cyc(A_DATA, 32'(i), 1, 0, 0);
    cyc(A_STAT, 0, 0, 0, 0);
    total++; if (bus.d_data_r !== 32'h0000_1005) begin bad++; $display("FAIL ovf_stat got=%h exp=00001005", bus.d_data_r); end
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.cons_valid !== 1'b1 || bus.cons_data !== 8'(i)) begin bad++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, bus.cons_valid, bus.cons_data, i); end
      cyc(A_RSV, 0, 0, 1, 0);
    end
    total++; if (bus.cons_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", bus.cons_valid); end
    cyc(A_STAT, 0, 0, 1, 0);
    total++; if (bus.d_data_r !== 32'h6) begin bad++; $display("FAIL ovf_empty_stat got=%h exp=6", bus.d_data_r); end
    cyc(A_STAT, 32'h4, 1, 0, 0);
    cyc(A_STAT, 0, 0, 0, 0);
    total++; if (bus.d_data_r !== 32'h2) begin bad++; $display("FAIL ovf_clear got=%h exp=2", bus.d_data_r); end
  endtask

  task automatic test_full_push_pop;
    for (int i = 0; i < 16; i++) cyc(A_DATA, 32'(8'h40 + i), 1, 0, 0);
    cyc(A_DATA, 32'hAA, 1, 1, 0);
    cyc(A_STAT, 0, 0, 0, 0);
    total++; if (bus.d_data_r !== 32'h0000_1001) begin bad++; $display("FAIL fpp_stat got=%h exp=00001001", bus.d_data_r); end
    for (int i = 1; i <= 16; i++) begin
      total++; if (bus.cons_valid !== 1'b1 || bus.cons_data !== (i == 16 ? 8'hAA : 8'(8'h40 + i))) begin bad++; $display("FAIL fpp_drain_%0d got=%b/%h", i, bus.cons_valid, bus.cons_data); end
      cyc(A_RSV, 0, 0, 1, 0);
    end
    total++; if (bus.cons_valid !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%b exp=0", bus.cons_valid); end
  endtask

  task automatic test_counter;
    cyc(A_CYC, 32'hFFFF_FFFE, 1, 0, 0);
    cyc(A_CYC, 0, 0, 0, 0);
    total++; if (bus.d_data_r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL cyc_load got=%h exp=fffffffe", bus.d_data_r); end
    cyc(A_CYC, 0, 0, 0, 0);
    total++; if (bus.d_data_r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cyc_inc got=%h exp=ffffffff", bus.d_data_r); end
    cyc(A_CYC, 0, 0, 0, 0);
    total++; if (bus.d_data_r !== 32'h0) begin bad++; $display("FAIL cyc_wrap got=%h exp=0", bus.d_data_r); end
  endtask

  task automatic test_reset_midop;
    cyc(32'h20, 32'h1234_5678, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(A_DATA, 32'(i + 7), 1, 0, 0);
    cyc(32'h20, 32'h0000_0BAD, 1, 0, 1);
    total++; if (bus.cons_valid !== 1'b0 || bus.cons_data !== 8'h0) begin bad++; $display("FAIL rst_fifo got=%b/%h exp=0/00", bus.cons_valid, bus.cons_data); end
    total++; if (bus.d_data_r !== 32'h0) begin bad++; $display("FAIL rst_rd got=%h exp=0", bus.d_data_r); end
    cyc(A_STAT, 0, 0, 0, 0);
    total++; if (bus.d_data_r !== 32'h2) begin bad++; $display("FAIL rst_stat got=%h exp=2", bus.d_data_r); end
    cyc(32'h20, 0, 0, 0, 0);
    total++; if (bus.d_data_r !== 32'h1234_5678) begin bad++; $display("FAIL rst_ram got=%h exp=12345678", bus.d_data_r); end
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int i = 0; i < 8; i++) cyc(32'(i * 4), $urandom, 1, 0, 0);
    for (int n = 0; n < 400; n++) begin
      a = $urandom_range(0, 1) ? {1'b1, 27'($urandom), 2'($urandom), 2'($urandom)}
                                : {1'b0, 17'($urandom), 9'h0, 3'($urandom), 2'($urandom)};
      cyc(a, $urandom, $urandom_range(0, 2) == 0, 1'($urandom), 0);
      if (exp_known) begin
        total++; if (bus.d_data_r !== exp_r) begin bad++; $display("FAIL rnd_rd n=%0d a=%h got=%h exp=%h", n, a, bus.d_data_r, exp_r); end
      end
      total++; if (bus.cons_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.cons_valid, m_q.size() != 0); end
      total++; if (bus.cons_data !== (m_q.size() != 0 ? m_q[0] : 8'h0)) begin bad++; $display("FAIL rnd_cdata n=%0d got=%h", n, bus.cons_data); end
    end
  endtask

  initial begin
    bus.d_addr = 0; bus.d_data_w = 0; bus.d_data_we = 0; bus.cons_ready = 0;
    test_reset;
    test_ram;
    test_latency;
    test_fifo_ovf;
    test_full_push_pop;
    test_counter;
    test_reset_midop;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
